// File: rtl/nibble_serial_alu_seq.sv
// Serial add/subtract unit: one 4-bit ripple slice reused across NIBBLES cycles,
// LSB nibble first, with carry held in a register between cycles.
module nibble_serial_alu_seq #(
  parameter int NIBBLES = 8,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ctrl_start,
  input  logic         ctrl_sub,
  input  logic [W-1:0] data_operandA,
  input  logic [W-1:0] data_operandB,
  output logic         data_busy,
  output logic         data_resultRDY,
  output logic [W-1:0] data_result,
  output logic         carry_out,
  output logic         overflow
);

  // state | meaning
  // IDLE  | waiting for ctrl_start
  // RUN   | one nibble per cycle through the slice
  // DONE  | result valid pulse; may accept a new start
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, result_q;
  logic [IW-1:0]  idx_q;
  logic           carry_q, carry_out_q, overflow_q;
  logic           accept, last;

  logic [3:0] a_nib, b_nib, sum_nib;
  logic [3:0] low;
  logic [1:0] high;
  logic       c3_in, c3_out;

  // The single 4-bit slice; the carry into bit 3 is kept for overflow.
  always_comb begin
    a_nib   = a_q[{idx_q, 2'b00} +: 4];
    b_nib   = b_q[{idx_q, 2'b00} +: 4];
    low     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    c3_in   = low[3];
    high    = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c3_in};
    c3_out  = high[1];
    sum_nib = {high[0], low[2:0]};
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ctrl_start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= data_operandA;
        b_q     <= ctrl_sub ? ~data_operandB : data_operandB;
        carry_q <= ctrl_sub;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        result_q[{idx_q, 2'b00} +: 4] <= sum_nib;
        carry_q <= c3_out;
        if (last) begin
          idx_q       <= '0;
          carry_out_q <= c3_out;
          overflow_q  <= c3_in ^ c3_out;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign data_busy      = (state_q == RUN);
  assign data_resultRDY = (state_q == DONE);
  assign data_result    = result_q;
  assign carry_out      = carry_out_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Bench for nibble_serial_alu_seq: vector table, handshake corner cases and
// random ops against a full-width reference, checked through a result queue.
module tb_nibble_serial_alu_seq;

  localparam int N   = 8;
  localparam int W   = 4 * N;
  localparam int LAT = N + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_start = 1'b0;
  logic         ctrl_sub = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         data_busy, data_resultRDY, carry_out, overflow;
  logic [W-1:0] data_result;

  nibble_serial_alu_seq #(.NIBBLES(N)) dut (
    .clock(clock), .reset(reset), .ctrl_start(ctrl_start), .ctrl_sub(ctrl_sub),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_busy(data_busy), .data_resultRDY(data_resultRDY),
    .data_result(data_result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } vec_t;

  exp_t exp_q[$];
  exp_t held;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: compare on every ready pulse, and check held values while idle.
  always @(negedge clock) begin
    if (reset) begin
      held = '0;
    end else if (data_resultRDY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 64'(data_resultRDY), 64'd0);
      end else begin
        held = exp_q.pop_front();
        check("result", 64'(data_result), 64'(held.res));
        check("carry_out", 64'(carry_out), 64'(held.c));
        check("overflow", 64'(overflow), 64'(held.v));
      end
    end else if (!data_busy) begin
      check("held_result", 64'(data_result), 64'(held.res));
      check("held_flags", {62'd0, carry_out, overflow}, {62'd0, held.c, held.v});
    end
  end

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input exp_t e);
    ctrl_start    = 1'b1;
    ctrl_sub      = sub;
    data_operandA = a;
    data_operandB = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_rdy(input int pulse_at);
    int cnt = 0;
    int busy_cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
      if (cnt == pulse_at) begin
        ctrl_start    = 1'b1;
        ctrl_sub      = 1'b0;
        data_operandA = '1;
        data_operandB = '1;
      end else begin
        ctrl_start = 1'b0;
      end
      if (data_busy) busy_cnt++;
    end while (!data_resultRDY && cnt < LAT + 10);
    check("latency", 64'(cnt), 64'(LAT));
    check("busy_cycles", 64'(busy_cnt), 64'(N));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0003, 32'h0000_000A, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_busy", 64'(data_busy), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_flags", {62'd0, carry_out, overflow}, 64'd0);

    foreach (vecs[i]) begin
      start_now(vecs[i].a, vecs[i].b, vecs[i].sub, '{vecs[i].res, vecs[i].c, vecs[i].v});
      wait_rdy(0);
      @(negedge clock);
    end

    // Start pulse mid-run is ignored, then a back-to-back start from DONE.
    start_now(32'h1234_5678, 32'h1111_1111, 1'b0, '{32'h2345_6789, 1'b0, 1'b0});
    wait_rdy(3);
    start_now(32'h0000_000A, 32'h0000_0003, 1'b1, '{32'h0000_0007, 1'b1, 1'b0});
    wait_rdy(0);
    @(negedge clock);

    // Reset in RUN cycle 4, with a simultaneous start that must lose.
    ctrl_start    = 1'b1;
    ctrl_sub      = 1'b0;
    data_operandA = 32'h0000_0100;
    data_operandB = 32'h0000_0200;
    @(negedge clock);
    ctrl_start = 1'b0;
    repeat (3) @(negedge clock);
    check("run_before_reset", 64'(data_busy), 64'd1);
    reset      = 1'b1;
    ctrl_start = 1'b1;
    @(negedge clock);
    reset      = 1'b0;
    ctrl_start = 1'b0;
    check("abort_busy", 64'(data_busy), 64'd0);
    check("abort_result", 64'(data_result), 64'd0);
    check("abort_flags", {62'd0, carry_out, overflow}, 64'd0);
    begin
      int rdy_seen = 0;
      repeat (LAT + 4) begin
        @(negedge clock);
        if (data_resultRDY || data_busy) rdy_seen++;
      end
      check("no_rdy_after_abort", 64'(rdy_seen), 64'd0);
    end
    start_now(32'h0000_0002, 32'h0000_0002, 1'b0, '{32'h0000_0004, 1'b0, 1'b0});
    wait_rdy(0);

    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] a, b;
      logic         s;
      a = $urandom();
      b = $urandom();
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = a;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clock);
      start_now(a, b, s, model(a, b, s));
      wait_rdy(0);
    end
    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
